dphy_lane_tx_ctrl: RTL

Synthesizable per-lane sequencer for one MIPI D-PHY data lane transmitter. Takes a byte stream with valid/ready/last from the packet builder and walks the lane through the full LP-to-HS-to-LP burst: LP-11 stop, LP-01 request, LP-00 prepare, HS-zero, sync byte 0xB8, payload, trail and exit. It drives the LP pad levels and an HS enable, and feeds a byte-wide stream to the downstream LSB-first serializer. All timing counts are in byte-clock cycles.

---
 rtl/dphy_lane_tx_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dphy_lane_tx_ctrl.sv
// Per-lane MIPI D-PHY data-lane TX sequencer: LP-11 -> LP-01 -> LP-00 -> HS burst -> trail -> LP-11.
// Optional packet counter output pkt_cnt_o is enabled by defining DPHY_PKT_CNT_EN.
`timescale 1ns/1ps
module dphy_lane_tx_ctrl #(
  parameter int T_LPX        = 2,
  parameter int T_HS_PREPARE = 3,
  parameter int T_HS_ZERO    = 4,
  parameter int T_HS_TRAIL   = 3,
  parameter int T_HS_EXIT    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tx_req_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_vld_i,
  input  logic        tx_last_i,
  output logic        tx_rdy_o,
  output logic        busy_o,
  output logic        lp_p_o,
  output logic        lp_n_o,
  output logic        hs_en_o,
  output logic [7:0]  hs_data_o,
  output logic        hs_vld_o,
  output logic        underrun_o,
  input  logic        err_clr_i
`ifdef DPHY_PKT_CNT_EN
  , output logic [15:0] pkt_cnt_o
`endif
);

  typedef enum logic [3:0] {
    IDLE, LP_RQST, LP_BRIDGE, HS_ZERO, HS_SYNC, HS_DATA, HS_LAST, HS_TRAIL, HS_EXIT
  } state_t;

  // Durations below 1 are clamped to 1; the counter holds (duration - 1).
  function automatic logic [7:0] load_val(input int t);
    return (t <= 1) ? 8'd0 : 8'(t - 1);
  endfunction

  localparam logic [7:0] LPX_LD   = load_val(T_LPX);
  localparam logic [7:0] PREP_LD  = load_val(T_HS_PREPARE);
  localparam logic [7:0] ZERO_LD  = load_val(T_HS_ZERO);
  localparam logic [7:0] TRAIL_LD = load_val(T_HS_TRAIL);
  localparam logic [7:0] EXIT_LD  = load_val(T_HS_EXIT);

  state_t     state;
  logic [7:0] cnt;
  logic       underrun_evt;
  logic [7:0] trail_fill;

  assign underrun_evt = tx_rdy_o & ~tx_vld_i;
  // Fill is the inverse of the last serialized bit (MSB of the byte currently on the lane).
  assign trail_fill   = {8{~hs_data_o[7]}};
  assign hs_vld_o     = hs_en_o;

  // NOTE: every output written here gets a default first, so no latch can be inferred.
  always_comb begin
    busy_o   = 1'b1;
    lp_p_o   = 1'b0;
    lp_n_o   = 1'b0;
    hs_en_o  = 1'b0;
    tx_rdy_o = 1'b0;
    case (state)
      IDLE:    begin busy_o = 1'b0; lp_p_o = 1'b1; lp_n_o = 1'b1; end
      LP_RQST: lp_n_o = 1'b1;
      HS_ZERO, HS_LAST, HS_TRAIL: hs_en_o = 1'b1;
      HS_SYNC, HS_DATA: begin hs_en_o = 1'b1; tx_rdy_o = 1'b1; end
      HS_EXIT: begin lp_p_o = 1'b1; lp_n_o = 1'b1; end
      default: ;
    endcase
  end

`ifdef DPHY_PKT_CNT_EN
  logic burst_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      burst_ok  <= 1'b0;
      pkt_cnt_o <= 16'h0000;
    end else begin
      if (state == IDLE && tx_req_i)
        burst_ok <= 1'b0;
      else if (state == HS_LAST)
        burst_ok <= 1'b1;
      if (state == HS_TRAIL && cnt == 8'd0 && burst_ok)
        pkt_cnt_o <= pkt_cnt_o + 16'd1;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      hs_data_o  <= 8'h00;
      underrun_o <= 1'b0;
    end else begin
      if (underrun_evt)
        underrun_o <= 1'b1;
      else if (err_clr_i)
        underrun_o <= 1'b0;

      case (state)
        IDLE: if (tx_req_i) begin
          state <= LP_RQST;
          cnt   <= LPX_LD;
        end
        LP_RQST: if (cnt == 8'd0) begin
          state <= LP_BRIDGE;
          cnt   <= PREP_LD;
        end else cnt <= cnt - 8'd1;
        LP_BRIDGE: if (cnt == 8'd0) begin
          state     <= HS_ZERO;
          cnt       <= ZERO_LD;
          hs_data_o <= 8'h00;
        end else cnt <= cnt - 8'd1;
        HS_ZERO: if (cnt == 8'd0) begin
          state     <= HS_SYNC;
          hs_data_o <= 8'hB8;
        end else cnt <= cnt - 8'd1;
        HS_SYNC, HS_DATA: if (tx_vld_i) begin
          hs_data_o <= tx_data_i;
          state     <= tx_last_i ? HS_LAST : HS_DATA;
        end else begin
          state     <= HS_TRAIL;
          cnt       <= TRAIL_LD;
          hs_data_o <= trail_fill;
        end
        HS_LAST: begin
          state     <= HS_TRAIL;
          cnt       <= TRAIL_LD;
          hs_data_o <= trail_fill;
        end
        HS_TRAIL: if (cnt == 8'd0) begin
          state     <= HS_EXIT;
          cnt       <= EXIT_LD;
          hs_data_o <= 8'h00;
        end else cnt <= cnt - 8'd1;
        HS_EXIT: if (cnt == 8'd0) state <= IDLE;
        else cnt <= cnt - 8'd1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
